control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter OPW, default 4, opcode width taken from ir[15:12].
REQ-002 clock  in  1  system clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 run  in  1  level; 1 = execute instructions, 0 = stop at the next instruction boundary.
REQ-005 ir  in  16  instruction register contents, valid from the DECODE state onward.
REQ-006 alu_flag  in  4  ALU flags {Z,C,N,O} in bits [3:0]; Z is bit 3.
REQ-007 halted  out  1  high while in HALT.
REQ-008 t_state  out  3  state code: IDLE=0, FETCH_L=1, FETCH_H=2, DECODE=3, EXEC=4, HALT=7.
REQ-009 outasel, outbsel, muxsel_a, muxsel_b  out  2 each  system mux selects; outbsel 00=PC, 01=AR.
REQ-010 funsel_ir, funsel_arf, funsel_rf  out  2 each  register functions: 00 clear, 01 load, 10 decrement, 11 increment.
REQ-011 funsel_alu  out  4; regsel_rf, regsel_arf  out  4 each  one-hot enables, active-high; ARF bit0=PC, bit1=AR, bit2=SP.
REQ-012 cs_mem, wr_mem, ir_enable, ir_lh, muxsel_c  out  1 each; rf_o1sel, rf_o2sel  out  3 each; rf_tsel  out  4.

Function
REQ-013 The FSM SHALL use the states IDLE, FETCH_L, FETCH_H, DECODE, EXEC and HALT, with all outputs decoded from state and ir (Moore, plus ir/alu_flag in EXEC).
REQ-014 Outside the actions listed below, all enables (regsel_*, ir_enable, cs_mem, wr_mem) SHALL be 0, and all selects SHALL be 0.
REQ-015 IDLE→FETCH_L when run=1; FETCH_L→FETCH_H→DECODE→EXEC unconditionally; EXEC→FETCH_L if run=1, else IDLE.
REQ-016 FETCH_L: cs_mem=1, wr_mem=0, outbsel=00, ir_enable=1, funsel_ir=01, ir_lh=0, regsel_arf=0001, funsel_arf=11.
REQ-017 FETCH_H: same as FETCH_L except ir_lh=1.
REQ-018 Instruction fields: Rd=ir[11:10], Rs1=ir[9:8], Rs2=ir[7:6], imm=ir[7:0]; register selects SHALL be {1'b0,Rsx} and regsel_rf=one-hot(Rd).
REQ-019 EXEC 0x0 NOP: no enables.
REQ-020 EXEC 0x1 LDI: muxsel_a=01 (IR low), funsel_rf=01, regsel_rf=one-hot(Rd).
REQ-021 EXEC 0x2-0x7 ALU: funsel_alu={1'b0,op[2:0]}, rf_o1sel=Rs1, rf_o2sel=Rs2, muxsel_c=0, muxsel_a=00, funsel_rf=01, Rd enabled.
REQ-022 EXEC 0x8 LD: cs_mem=1, wr_mem=0, outbsel=01, muxsel_a=10, funsel_rf=01, Rd enabled.
REQ-023 EXEC 0x9 ST: rf_o1sel=Rs1, funsel_alu=0000 (pass A), cs_mem=1, wr_mem=1 for exactly one cycle, outbsel=01.
REQ-024 EXEC 0xA BZ: if alu_flag[3]=1, muxsel_b=10, funsel_arf=01, regsel_arf=0001; if alu_flag[3]=0, no enables.
REQ-025 EXEC 0xB LDAR: muxsel_b=10, funsel_arf=01, regsel_arf=0010.
REQ-026 EXEC 0xF HLT: enter HALT; HALT is held regardless of run until reset; opcodes 0xC-0xE SHALL execute as NOP.
REQ-027 Each instruction SHALL take exactly 4 cycles; PC wrap is owned by the ARF, and the controller performs no range check.
REQ-028 When run falls mid-instruction, the current instruction SHALL complete before the FSM enters IDLE.

Reset
REQ-029 reset=1 SHALL force IDLE at the next edge, from any state, including HALT and mid-fetch.
REQ-030 While in reset and in the cycle following it, all enables SHALL be 0, halted=0 and t_state=0, so no memory write or register load occurs.
REQ-031 reset SHALL take priority over run.

Structure
REQ-032 Opcode values, funsel encodings, mux-select codes and state encodings SHALL live in a shared package, cu_pkg.
REQ-033 One sub-module, cu_decode (combinational ir-to-control mapping for EXEC), SHALL be instantiated; the FSM stays in control_unit.

Verification
REQ-034 Reset held 3 cycles with run=1 -> t_state=0, halted=0, all enables 0.
REQ-035 run=1, ir=16'h14A5 (LDI R1) -> cycle 1: cs_mem=1, ir_lh=0, regsel_arf=0001, funsel_arf=11; cycle 2: ir_lh=1; cycle 4: regsel_rf=0010, muxsel_a=01, funsel_rf=01.
REQ-036 ir=16'h3180 -> EXEC: funsel_alu=0011, rf_o1sel=001, rf_o2sel=010, regsel_rf=0001.
REQ-037 ir=16'hA040 with alu_flag=4'b1000 -> EXEC regsel_arf=0001, muxsel_b=10; repeated with alu_flag=0 -> regsel_arf=0000.
REQ-038 ir=16'h9100 -> wr_mem=1 in EXEC only, outbsel=01; run dropped during FETCH_H -> ST completes, then IDLE.
REQ-039 ir=16'hF000 -> halted=1 held for 10 cycles with run=1; reset asserted in FETCH_H of a later instruction -> IDLE next cycle, ir_enable=0.

Source files
------------

// File: rtl/cu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cu_pkg
//  Description : Shared encodings for the control unit: FSM state codes,
//                opcodes, register-function codes, mux-select codes, the
//                control-word struct and small helper functions.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package cu_pkg;

   // State codes are visible on t_state, so the values are fixed.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH_L = 3'd1,
      S_FETCH_H = 3'd2,
      S_DECODE  = 3'd3,
      S_EXEC    = 3'd4,
      S_HALT    = 3'd7
   } state_t;

   // Opcodes (ir[15:12])
   localparam logic [3:0] OP_NOP       = 4'h0;
   localparam logic [3:0] OP_LDI       = 4'h1;
   localparam logic [3:0] OP_ALU_FIRST = 4'h2;
   localparam logic [3:0] OP_ALU_LAST  = 4'h7;
   localparam logic [3:0] OP_LD        = 4'h8;
   localparam logic [3:0] OP_ST        = 4'h9;
   localparam logic [3:0] OP_BZ        = 4'hA;
   localparam logic [3:0] OP_LDAR      = 4'hB;
   localparam logic [3:0] OP_HLT       = 4'hF;

   // Register functions (IR, ARF, RF); 2'b10 is decrement, not issued here.
   localparam logic [1:0] FUN_CLEAR = 2'b00;
   localparam logic [1:0] FUN_LOAD  = 2'b01;
   localparam logic [1:0] FUN_INC   = 2'b11;

   // Mux selects
   localparam logic [1:0] MUXA_ALU  = 2'b00;
   localparam logic [1:0] MUXA_IRL  = 2'b01;
   localparam logic [1:0] MUXA_MEM  = 2'b10;
   localparam logic [1:0] MUXB_IR   = 2'b10;
   localparam logic [1:0] OUTB_PC   = 2'b00;
   localparam logic [1:0] OUTB_AR   = 2'b01;

   localparam logic [3:0] ALU_PASS_A = 4'b0000;
   localparam logic [3:0] ARF_PC     = 4'b0001;
   localparam logic [3:0] ARF_AR     = 4'b0010;
   localparam int         FLAG_Z     = 3;

   typedef struct packed {
      logic [1:0] outasel;
      logic [1:0] outbsel;
      logic [1:0] muxsel_a;
      logic [1:0] muxsel_b;
      logic [1:0] funsel_ir;
      logic [1:0] funsel_arf;
      logic [1:0] funsel_rf;
      logic [3:0] funsel_alu;
      logic [3:0] regsel_rf;
      logic [3:0] regsel_arf;
      logic       cs_mem;
      logic       wr_mem;
      logic       ir_enable;
      logic       ir_lh;
      logic       muxsel_c;
      logic [2:0] rf_o1sel;
      logic [2:0] rf_o2sel;
      logic [3:0] rf_tsel;
   } ctrl_t;

   // Quiescent control word: no enables, all selects zero.
   function automatic ctrl_t ctrl_none();
      ctrl_t c;
      c            = '0;
      c.funsel_ir  = FUN_CLEAR;
      c.funsel_arf = FUN_CLEAR;
      c.funsel_rf  = FUN_CLEAR;
      return c;
   endfunction

   function automatic logic [3:0] onehot4(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

   // Both fetch halves read memory at PC, load one IR byte and bump PC.
   function automatic ctrl_t fetch_ctrl(input logic high_half);
      ctrl_t c;
      c            = ctrl_none();
      c.cs_mem     = 1'b1;
      c.outbsel    = OUTB_PC;
      c.ir_enable  = 1'b1;
      c.funsel_ir  = FUN_LOAD;
      c.ir_lh      = high_half;
      c.regsel_arf = ARF_PC;
      c.funsel_arf = FUN_INC;
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cu_decode.sv
`default_nettype none
// ============================================================================
//  Module      : cu_decode
//  Description : Combinational mapping from the instruction register (and the
//                Z flag for BZ) to the control word driven during EXEC.
//  Ports       : ir       in  16  instruction register
//                alu_flag in  4   {Z,C,N,O}, Z in bit 3
//                ctrl     out     EXEC control word
//                hlt      out 1   instruction is HLT
//  Revision    : 1.0  initial release
// ============================================================================
module cu_decode
   import cu_pkg::*;
#(
   parameter int OPW = 4
) (
   input  logic [15:0] ir,
   input  logic [3:0]  alu_flag,
   output ctrl_t       ctrl,
   output logic        hlt
);

   logic [OPW-1:0] op;
   logic [1:0]     rd;
   logic [1:0]     rs1;
   logic [1:0]     rs2;
   logic           unused_bits;

   assign op  = ir[15 -: OPW];
   assign rd  = ir[11:10];
   assign rs1 = ir[9:8];
   assign rs2 = ir[7:6];
   assign hlt = (op == OP_HLT);

   // Low IR byte reaches the RF through muxsel_a, C/N/O only matter to the ALU.
   assign unused_bits = ^{ir[5:0], alu_flag[2:0]};

   always_comb begin
      ctrl = ctrl_none();
      case (op) inside
         OP_NOP: ;
         OP_LDI: begin
            ctrl.muxsel_a  = MUXA_IRL;
            ctrl.funsel_rf = FUN_LOAD;
            ctrl.regsel_rf = onehot4(rd);
         end
         [OP_ALU_FIRST:OP_ALU_LAST]: begin
            ctrl.funsel_alu = {1'b0, op[2:0]};
            ctrl.rf_o1sel   = {1'b0, rs1};
            ctrl.rf_o2sel   = {1'b0, rs2};
            ctrl.muxsel_c   = 1'b0;
            ctrl.muxsel_a   = MUXA_ALU;
            ctrl.funsel_rf  = FUN_LOAD;
            ctrl.regsel_rf  = onehot4(rd);
         end
         OP_LD: begin
            ctrl.cs_mem    = 1'b1;
            ctrl.wr_mem    = 1'b0;
            ctrl.outbsel   = OUTB_AR;
            ctrl.muxsel_a  = MUXA_MEM;
            ctrl.funsel_rf = FUN_LOAD;
            ctrl.regsel_rf = onehot4(rd);
         end
         OP_ST: begin
            ctrl.rf_o1sel   = {1'b0, rs1};
            ctrl.funsel_alu = ALU_PASS_A;
            ctrl.cs_mem     = 1'b1;
            ctrl.wr_mem     = 1'b1;
            ctrl.outbsel    = OUTB_AR;
         end
         OP_BZ: begin
            if (alu_flag[FLAG_Z]) begin
               ctrl.muxsel_b   = MUXB_IR;
               ctrl.funsel_arf = FUN_LOAD;
               ctrl.regsel_arf = ARF_PC;
            end
         end
         OP_LDAR: begin
            ctrl.muxsel_b   = MUXB_IR;
            ctrl.funsel_arf = FUN_LOAD;
            ctrl.regsel_arf = ARF_AR;
         end
         // 0xC-0xE behave as NOP; HLT itself drives no enables.
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit
//  Description : Four-cycle instruction sequencer (FETCH_L, FETCH_H, DECODE,
//                EXEC) with IDLE and HALT, driving datapath mux selects,
//                register functions and memory strobes.
//  Ports       : clock, reset (sync, active-high), run, ir[15:0],
//                alu_flag[3:0] in; halted, t_state[2:0], mux selects,
//                register functions/enables, memory strobes, RF selects out.
//  Revision    : 1.0  initial release
// ============================================================================
module control_unit
   import cu_pkg::*;
#(
   parameter int OPW = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        run,
   input  logic [15:0] ir,
   input  logic [3:0]  alu_flag,
   output logic        halted,
   output logic [2:0]  t_state,
   output logic [1:0]  outasel,
   output logic [1:0]  outbsel,
   output logic [1:0]  muxsel_a,
   output logic [1:0]  muxsel_b,
   output logic [1:0]  funsel_ir,
   output logic [1:0]  funsel_arf,
   output logic [1:0]  funsel_rf,
   output logic [3:0]  funsel_alu,
   output logic [3:0]  regsel_rf,
   output logic [3:0]  regsel_arf,
   output logic        cs_mem,
   output logic        wr_mem,
   output logic        ir_enable,
   output logic        ir_lh,
   output logic        muxsel_c,
   output logic [2:0]  rf_o1sel,
   output logic [2:0]  rf_o2sel,
   output logic [3:0]  rf_tsel
);

   state_t state;
   ctrl_t  exec_ctrl;
   ctrl_t  ctrl;
   logic   is_hlt;

   cu_decode #(
      .OPW (OPW)
   ) u_decode (
      .ir       (ir),
      .alu_flag (alu_flag),
      .ctrl     (exec_ctrl),
      .hlt      (is_hlt)
   );

   // HALT is only left through reset; run is sampled only at EXEC/IDLE so a
   // falling run lets the current instruction finish.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE:    if (run) state <= S_FETCH_L;
            S_FETCH_L: state <= S_FETCH_H;
            S_FETCH_H: state <= S_DECODE;
            S_DECODE:  state <= S_EXEC;
            S_EXEC: begin
               if (is_hlt)   state <= S_HALT;
               else if (run) state <= S_FETCH_L;
               else          state <= S_IDLE;
            end
            S_HALT:    state <= S_HALT;
            default:   state <= S_IDLE;
         endcase
      end
   end

   // Reset masks the decode so no strobe escapes in the cycle reset is seen,
   // even when the state register still holds a fetch or EXEC state.
   always_comb begin
      ctrl = ctrl_none();
      if (!reset) begin
         case (state)
            S_FETCH_L: ctrl = fetch_ctrl(1'b0);
            S_FETCH_H: ctrl = fetch_ctrl(1'b1);
            S_EXEC:    ctrl = exec_ctrl;
            default:   ;
         endcase
      end
   end

   assign halted     = (state == S_HALT) && !reset;
   assign t_state    = reset ? 3'd0 : state;
   assign outasel    = ctrl.outasel;
   assign outbsel    = ctrl.outbsel;
   assign muxsel_a   = ctrl.muxsel_a;
   assign muxsel_b   = ctrl.muxsel_b;
   assign funsel_ir  = ctrl.funsel_ir;
   assign funsel_arf = ctrl.funsel_arf;
   assign funsel_rf  = ctrl.funsel_rf;
   assign funsel_alu = ctrl.funsel_alu;
   assign regsel_rf  = ctrl.regsel_rf;
   assign regsel_arf = ctrl.regsel_arf;
   assign cs_mem     = ctrl.cs_mem;
   assign wr_mem     = ctrl.wr_mem;
   assign ir_enable  = ctrl.ir_enable;
   assign ir_lh      = ctrl.ir_lh;
   assign muxsel_c   = ctrl.muxsel_c;
   assign rf_o1sel   = ctrl.rf_o1sel;
   assign rf_o2sel   = ctrl.rf_o2sel;
   assign rf_tsel    = ctrl.rf_tsel;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_unit
//  Description : Self-checking bench for control_unit: a table of
//                instructions with their expected EXEC control words, plus
//                hand sequences for reset, run-drop, HALT and mid-fetch reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_control_unit;

   typedef struct packed {
      logic [2:0] t_state;
      logic       halted;
      logic [1:0] outasel;
      logic [1:0] outbsel;
      logic [1:0] muxsel_a;
      logic [1:0] muxsel_b;
      logic [1:0] funsel_ir;
      logic [1:0] funsel_arf;
      logic [1:0] funsel_rf;
      logic [3:0] funsel_alu;
      logic [3:0] regsel_rf;
      logic [3:0] regsel_arf;
      logic       cs_mem;
      logic       wr_mem;
      logic       ir_enable;
      logic       ir_lh;
      logic       muxsel_c;
      logic [2:0] rf_o1sel;
      logic [2:0] rf_o2sel;
      logic [3:0] rf_tsel;
   } obs_t;

   typedef struct {
      logic [15:0] ir;
      logic [3:0]  flag;
      obs_t        exp;
   } vec_t;

   logic        clock;
   logic        reset;
   logic        run;
   logic [15:0] ir;
   logic [3:0]  alu_flag;
   logic        halted;
   logic [2:0]  t_state;
   logic [1:0]  outasel, outbsel, muxsel_a, muxsel_b;
   logic [1:0]  funsel_ir, funsel_arf, funsel_rf;
   logic [3:0]  funsel_alu, regsel_rf, regsel_arf;
   logic        cs_mem, wr_mem, ir_enable, ir_lh, muxsel_c;
   logic [2:0]  rf_o1sel, rf_o2sel;
   logic [3:0]  rf_tsel;

   int   n_cmp = 0;
   int   n_bad = 0;
   obs_t exp_q[$];
   vec_t vecs[14];

   control_unit #(.OPW(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .run        (run),
      .ir         (ir),
      .alu_flag   (alu_flag),
      .halted     (halted),
      .t_state    (t_state),
      .outasel    (outasel),
      .outbsel    (outbsel),
      .muxsel_a   (muxsel_a),
      .muxsel_b   (muxsel_b),
      .funsel_ir  (funsel_ir),
      .funsel_arf (funsel_arf),
      .funsel_rf  (funsel_rf),
      .funsel_alu (funsel_alu),
      .regsel_rf  (regsel_rf),
      .regsel_arf (regsel_arf),
      .cs_mem     (cs_mem),
      .wr_mem     (wr_mem),
      .ir_enable  (ir_enable),
      .ir_lh      (ir_lh),
      .muxsel_c   (muxsel_c),
      .rf_o1sel   (rf_o1sel),
      .rf_o2sel   (rf_o2sel),
      .rf_tsel    (rf_tsel)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic obs_t sample();
      obs_t o;
      o.t_state    = t_state;
      o.halted     = halted;
      o.outasel    = outasel;
      o.outbsel    = outbsel;
      o.muxsel_a   = muxsel_a;
      o.muxsel_b   = muxsel_b;
      o.funsel_ir  = funsel_ir;
      o.funsel_arf = funsel_arf;
      o.funsel_rf  = funsel_rf;
      o.funsel_alu = funsel_alu;
      o.regsel_rf  = regsel_rf;
      o.regsel_arf = regsel_arf;
      o.cs_mem     = cs_mem;
      o.wr_mem     = wr_mem;
      o.ir_enable  = ir_enable;
      o.ir_lh      = ir_lh;
      o.muxsel_c   = muxsel_c;
      o.rf_o1sel   = rf_o1sel;
      o.rf_o2sel   = rf_o2sel;
      o.rf_tsel    = rf_tsel;
      return o;
   endfunction

   // Quiet word in a given state (IDLE, DECODE, reset).
   function automatic obs_t quiet_exp(input logic [2:0] ts);
      obs_t o;
      o         = '0;
      o.t_state = ts;
      return o;
   endfunction

   function automatic obs_t halt_exp();
      obs_t o;
      o         = '0;
      o.t_state = 3'd7;
      o.halted  = 1'b1;
      return o;
   endfunction

   function automatic obs_t fetch_exp(input logic lh);
      obs_t o;
      o            = '0;
      o.t_state    = lh ? 3'd2 : 3'd1;
      o.cs_mem     = 1'b1;
      o.outbsel    = 2'b00;
      o.ir_enable  = 1'b1;
      o.funsel_ir  = 2'b01;
      o.ir_lh      = lh;
      o.regsel_arf = 4'b0001;
      o.funsel_arf = 2'b11;
      return o;
   endfunction

   function automatic obs_t exec_exp(
      input logic [3:0] rrf, input logic [3:0] rarf, input logic [3:0] falu,
      input logic [2:0] o1, input logic [2:0] o2, input logic [1:0] ma,
      input logic [1:0] mb, input logic [1:0] frf, input logic [1:0] farf,
      input logic cs, input logic wr, input logic [1:0] outb);
      obs_t o;
      o            = '0;
      o.t_state    = 3'd4;
      o.regsel_rf  = rrf;
      o.regsel_arf = rarf;
      o.funsel_alu = falu;
      o.rf_o1sel   = o1;
      o.rf_o2sel   = o2;
      o.muxsel_a   = ma;
      o.muxsel_b   = mb;
      o.funsel_rf  = frf;
      o.funsel_arf = farf;
      o.cs_mem     = cs;
      o.wr_mem     = wr;
      o.outbsel    = outb;
      return o;
   endfunction

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic check(input string name, input obs_t exp);
      obs_t act;
      act = sample();
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h (t_state=%0d) expected %h (t_state=%0d)",
                  name, act, act.t_state, exp, exp.t_state);
      end
   endtask

   // Scoreboard pop: called in the cycle the DUT should be in EXEC.
   task automatic check_exec(input string name);
      obs_t e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: scoreboard empty, got t_state=%0d expected a queued EXEC word",
                  name, t_state);
      end else begin
         e = exp_q.pop_front();
         check(name, e);
      end
   endtask

   // One full instruction with run held high, entered from IDLE or EXEC.
   task automatic run_instr(input string name, input logic [15:0] i_ir,
                            input logic [3:0] flag, input obs_t exp);
      tick();
      check({name, "_fetch_l"}, fetch_exp(1'b0));
      ir       = i_ir;
      alu_flag = flag;
      exp_q.push_back(exp);
      tick();
      check({name, "_fetch_h"}, fetch_exp(1'b1));
      tick();
      check({name, "_decode"}, quiet_exp(3'd3));
      tick();
      check_exec({name, "_exec"});
   endtask

   initial begin
      vecs[0]  = '{16'h0123, 4'h0, exec_exp(4'b0000, 4'b0000, 4'h0, 3'd0, 3'd0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00)};
      vecs[1]  = '{16'h14A5, 4'h0, exec_exp(4'b0010, 4'b0000, 4'h0, 3'd0, 3'd0, 2'b01, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00)};
      vecs[2]  = '{16'h3180, 4'h0, exec_exp(4'b0001, 4'b0000, 4'h3, 3'd1, 3'd2, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00)};
      vecs[3]  = '{16'h7E40, 4'h0, exec_exp(4'b1000, 4'b0000, 4'h7, 3'd2, 3'd1, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00)};
      vecs[4]  = '{16'h2000, 4'hF, exec_exp(4'b0001, 4'b0000, 4'h2, 3'd0, 3'd0, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00)};
      vecs[5]  = '{16'h8800, 4'h0, exec_exp(4'b0100, 4'b0000, 4'h0, 3'd0, 3'd0, 2'b10, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 2'b01)};
      vecs[6]  = '{16'h9100, 4'h0, exec_exp(4'b0000, 4'b0000, 4'h0, 3'd1, 3'd0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 2'b01)};
      vecs[7]  = '{16'hA040, 4'h8, exec_exp(4'b0000, 4'b0001, 4'h0, 3'd0, 3'd0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0, 2'b00)};
      vecs[8]  = '{16'hA040, 4'h0, exec_exp(4'b0000, 4'b0000, 4'h0, 3'd0, 3'd0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00)};
      vecs[9]  = '{16'hA040, 4'h7, exec_exp(4'b0000, 4'b0000, 4'h0, 3'd0, 3'd0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00)};
      vecs[10] = '{16'hB000, 4'h0, exec_exp(4'b0000, 4'b0010, 4'h0, 3'd0, 3'd0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0, 2'b00)};
      vecs[11] = '{16'hC5FF, 4'hF, exec_exp(4'b0000, 4'b0000, 4'h0, 3'd0, 3'd0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00)};
      vecs[12] = '{16'hEFFF, 4'h8, exec_exp(4'b0000, 4'b0000, 4'h0, 3'd0, 3'd0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00)};
      vecs[13] = '{16'hAFFF, 4'hF, exec_exp(4'b0000, 4'b0001, 4'h0, 3'd0, 3'd0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0, 2'b00)};

      reset    = 1'b1;
      run      = 1'b1;
      ir       = 16'h0000;
      alu_flag = 4'h0;

      // Reset held three cycles with run high.
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("reset_cycle_%0d", i), quiet_exp(3'd0));
      end
      reset = 1'b0;
      #1;
      check("post_reset_idle", quiet_exp(3'd0));

      // Table of instructions, back to back with run high.
      for (int i = 0; i < 14; i++) begin
         run_instr($sformatf("vec%0d_%h", i, vecs[i].ir), vecs[i].ir, vecs[i].flag, vecs[i].exp);
      end

      // ST with run dropped during FETCH_H: the store completes, then IDLE.
      tick();
      check("st_fetch_l", fetch_exp(1'b0));
      ir       = 16'h9100;
      alu_flag = 4'h0;
      exp_q.push_back(exec_exp(4'b0000, 4'b0000, 4'h0, 3'd1, 3'd0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 2'b01));
      tick();
      check("st_fetch_h", fetch_exp(1'b1));
      run = 1'b0;
      tick();
      check("st_decode", quiet_exp(3'd3));
      tick();
      check_exec("st_exec");
      tick();
      check("st_then_idle", quiet_exp(3'd0));
      tick();
      check("idle_hold_run0", quiet_exp(3'd0));

      // HLT: HALT persists regardless of run.
      run = 1'b1;
      run_instr("hlt", 16'hF000, 4'h0, quiet_exp(3'd4));
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("halt_hold_%0d", i), halt_exp());
         if (i == 4) run = 1'b0;
      end
      run   = 1'b1;
      reset = 1'b1;
      tick();
      check("halt_reset_idle", quiet_exp(3'd0));
      reset = 1'b0;

      // Reset arriving in FETCH_H of a later instruction.
      tick();
      check("refetch_l", fetch_exp(1'b0));
      ir = 16'h14A5;
      tick();
      check("refetch_h", fetch_exp(1'b1));
      reset = 1'b1;
      #1;
      check("reset_in_fetch_h", quiet_exp(3'd0));
      tick();
      check("reset_next_cycle", quiet_exp(3'd0));
      reset = 1'b0;
      #1;
      check("reset_release_idle", quiet_exp(3'd0));
      tick();
      check("restart_fetch_l", fetch_exp(1'b0));

      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
